// File: rtl/nbody_bus_master_if.sv
// ---------------------------------------------------------------------------
// nbody_bus_master_if
// Avalon-MM style bus between the host-side initiator (nbody_bus_master) and
// the nbody accelerator slave port.
//   addr       : {op[6:0], body index}
//   chipselect : bus select
//   read/write : transfer strobes
//   writedata  : initiator -> accelerator data
//   readdata   : accelerator -> initiator data
// ---------------------------------------------------------------------------
interface nbody_bus_master_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;

   modport master (
      output addr, chipselect, read, write, writedata,
      input  readdata
   );

   modport slave (
      input  addr, chipselect, read, write, writedata,
      output readdata
   );
endinterface

// File: rtl/nbody_bus_master.sv
// ---------------------------------------------------------------------------
// nbody_bus_master
// Host-side initiator for the nbody accelerator. Per frame it writes the
// configuration, optionally streams body state in, starts the accelerator,
// polls DONE, streams X/Y back out and performs the READ/GO release handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, load         : frame request (IDLE only) and "stream bodies first"
//   num_bodies_cfg      : body count for the frame
//   gap_cfg             : integration steps per frame
//   in_valid/ready/data : body-word input stream (x, y, m, vx, vy per body)
//   out_valid/ready/data/last : readback stream (x, y per body)
//   busy, frame_done, timeout : status
//   bus                 : accelerator bus (master modport)
// ---------------------------------------------------------------------------
module nbody_bus_master #(
   parameter int BODIES          = 512,
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 16,
   parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
   parameter int POLL_GAP        = 16,
   parameter int MAX_POLLS       = 1048576
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       load,
   input  logic [BODY_ADDR_WIDTH-1:0] num_bodies_cfg,
   input  logic [BODY_ADDR_WIDTH-1:0] gap_cfg,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_last,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       timeout,
   nbody_bus_master_if.master         bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CFG_N, S_CFG_GAP, S_LOAD, S_GO_SET, S_POLL_WAIT, S_POLL_RD,
      S_READBACK, S_OUT_HOLD, S_REL_READ, S_REL_GO, S_REL_CLR
   } state_t;

   typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_CAPTURE} phase_t;

   localparam logic [6:0] OP_GO      = 7'd0;
   localparam logic [6:0] OP_READ    = 7'd1;
   localparam logic [6:0] OP_NBODIES = 7'd2;
   localparam logic [6:0] OP_X       = 7'd3;
   localparam logic [6:0] OP_GAP     = 7'd8;
   localparam logic [6:0] OP_DONE_RD = 7'd64;
   localparam logic [6:0] OP_X_RD    = 7'd65;
   localparam logic [6:0] OP_Y_RD    = 7'd66;

   localparam logic [BODY_ADDR_WIDTH-1:0] B_ZERO = '0;
   localparam logic [BODY_ADDR_WIDTH-1:0] B_ONE  = BODY_ADDR_WIDTH'(1);
   localparam logic [31:0]                MAXP   = 32'(MAX_POLLS);
   localparam logic [31:0]                GAPEND = 32'(POLL_GAP - 1);

   // Control state (reset)
   state_t                     state_q, state_d;
   phase_t                     phase_q, phase_d;
   logic [2:0]                 w_q, w_d;
   logic [BODY_ADDR_WIDTH-1:0] b_q, b_d;
   logic                       sel_y_q, sel_y_d;
   logic [31:0]                poll_q, poll_d;
   logic [31:0]                wait_q, wait_d;
   logic                       timed_out_q, timed_out_d;
   logic                       timeout_q, timeout_d;

   // Frame configuration and readback data (not reset)
   logic [BODY_ADDR_WIDTH-1:0] n_q, n_d;
   logic [BODY_ADDR_WIDTH-1:0] gap_q, gap_d;
   logic                       load_q, load_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic                       last_q, last_d;

   // Bus drive
   logic [ADDR_WIDTH-1:0]      addr_c;
   logic [DATA_WIDTH-1:0]      wdata_c;
   logic                       cs_c, rd_c, wr_c;
   logic                       in_ready_c, out_valid_c, frame_done_c;

   function automatic logic [ADDR_WIDTH-1:0] mk_addr(
      input logic [6:0] op, input logic [BODY_ADDR_WIDTH-1:0] body);
      logic [ADDR_WIDTH-1:0] a;
      a = '0;
      a[BODY_ADDR_WIDTH +: 7]    = op;
      a[BODY_ADDR_WIDTH-1:0]     = body;
      return a;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v >= MAXP) ? MAXP : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_SETUP;
         w_q         <= '0;
         b_q         <= '0;
         sel_y_q     <= 1'b0;
         poll_q      <= '0;
         wait_q      <= '0;
         timed_out_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         w_q         <= w_d;
         b_q         <= b_d;
         sel_y_q     <= sel_y_d;
         poll_q      <= poll_d;
         wait_q      <= wait_d;
         timed_out_q <= timed_out_d;
         timeout_q   <= timeout_d;
      end
   end

   always_ff @(posedge clk) begin
      n_q     <= n_d;
      gap_q   <= gap_d;
      load_q  <= load_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      w_d          = w_q;
      b_d          = b_q;
      sel_y_d      = sel_y_q;
      poll_d       = poll_q;
      wait_d       = wait_q;
      timed_out_d  = timed_out_q;
      timeout_d    = 1'b0;
      n_d          = n_q;
      gap_d        = gap_q;
      load_d       = load_q;
      rdata_d      = rdata_q;
      last_d       = last_q;
      addr_c       = '0;
      wdata_c      = '0;
      cs_c         = 1'b0;
      rd_c         = 1'b0;
      wr_c         = 1'b0;
      in_ready_c   = 1'b0;
      out_valid_c  = 1'b0;
      frame_done_c = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && (num_bodies_cfg != B_ZERO) && (gap_cfg != B_ZERO)) begin
               n_d         = num_bodies_cfg;
               gap_d       = gap_cfg;
               load_d      = load;
               timed_out_d = 1'b0;
               state_d     = S_CFG_N;
            end
         end

         S_CFG_N: begin
            cs_c    = 1'b1;
            wr_c    = 1'b1;
            addr_c  = mk_addr(OP_NBODIES, B_ZERO);
            wdata_c = DATA_WIDTH'(n_q);
            state_d = S_CFG_GAP;
         end

         S_CFG_GAP: begin
            cs_c    = 1'b1;
            wr_c    = 1'b1;
            addr_c  = mk_addr(OP_GAP, B_ZERO);
            wdata_c = DATA_WIDTH'(gap_q);
            w_d     = '0;
            b_d     = '0;
            state_d = load_q ? S_LOAD : S_GO_SET;
         end

         // Each accepted beat becomes a bus write in the same cycle; the
         // address walks X..VY for one body before moving to the next.
         S_LOAD: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               cs_c    = 1'b1;
               wr_c    = 1'b1;
               addr_c  = mk_addr(OP_X + {4'b0, w_q}, b_q);
               wdata_c = in_data;
               if (w_q == 3'd4) begin
                  w_d = '0;
                  if (b_q == n_q - B_ONE) begin
                     b_d     = '0;
                     state_d = S_GO_SET;
                  end else begin
                     b_d = b_q + B_ONE;
                  end
               end else begin
                  w_d = w_q + 3'd1;
               end
            end
         end

         S_GO_SET: begin
            cs_c    = 1'b1;
            wr_c    = 1'b1;
            addr_c  = mk_addr(OP_GO, B_ZERO);
            wdata_c = DATA_WIDTH'(1);
            poll_d  = '0;
            wait_d  = '0;
            phase_d = PH_SETUP;
            state_d = S_POLL_WAIT;
         end

         S_POLL_WAIT: begin
            if (wait_q == GAPEND) begin
               wait_d  = '0;
               phase_d = PH_SETUP;
               state_d = S_POLL_RD;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end

         // DONE is checked before the poll limit, so a DONE arriving on the
         // last allowed poll still completes the frame normally.
         S_POLL_RD: begin
            addr_c = mk_addr(OP_DONE_RD, B_ZERO);
            unique case (phase_q)
               PH_SETUP: begin
                  cs_c    = 1'b1;
                  phase_d = PH_STROBE;
               end
               PH_STROBE: begin
                  cs_c    = 1'b1;
                  rd_c    = 1'b1;
                  phase_d = PH_CAPTURE;
               end
               default: begin
                  phase_d = PH_SETUP;
                  if (bus.readdata[0]) begin
                     b_d     = '0;
                     sel_y_d = 1'b0;
                     state_d = S_READBACK;
                  end else begin
                     poll_d = sat_inc(poll_q);
                     if (sat_inc(poll_q) >= MAXP) begin
                        timeout_d   = 1'b1;
                        timed_out_d = 1'b1;
                        state_d     = S_REL_GO;
                     end else begin
                        state_d = S_POLL_WAIT;
                     end
                  end
               end
            endcase
         end

         S_READBACK: begin
            addr_c = mk_addr(sel_y_q ? OP_Y_RD : OP_X_RD, b_q);
            unique case (phase_q)
               PH_SETUP: begin
                  cs_c    = 1'b1;
                  phase_d = PH_STROBE;
               end
               PH_STROBE: begin
                  cs_c    = 1'b1;
                  rd_c    = 1'b1;
                  phase_d = PH_CAPTURE;
               end
               default: begin
                  phase_d = PH_SETUP;
                  rdata_d = bus.readdata;
                  last_d  = sel_y_q && (b_q == n_q - B_ONE);
                  state_d = S_OUT_HOLD;
               end
            endcase
         end

         // Only one readback word is ever in flight: the next read is not
         // issued until this one is accepted.
         S_OUT_HOLD: begin
            out_valid_c = 1'b1;
            if (out_ready) begin
               if (last_q) begin
                  state_d = S_REL_READ;
               end else if (!sel_y_q) begin
                  sel_y_d = 1'b1;
                  state_d = S_READBACK;
               end else begin
                  sel_y_d = 1'b0;
                  b_d     = b_q + B_ONE;
                  state_d = S_READBACK;
               end
            end
         end

         S_REL_READ: begin
            cs_c    = 1'b1;
            wr_c    = 1'b1;
            addr_c  = mk_addr(OP_READ, B_ZERO);
            wdata_c = DATA_WIDTH'(1);
            state_d = S_REL_GO;
         end

         // GO is cleared before READ so the accelerator cannot restart.
         S_REL_GO: begin
            cs_c    = 1'b1;
            wr_c    = 1'b1;
            addr_c  = mk_addr(OP_GO, B_ZERO);
            wdata_c = '0;
            state_d = S_REL_CLR;
         end

         S_REL_CLR: begin
            cs_c         = 1'b1;
            wr_c         = 1'b1;
            addr_c       = mk_addr(OP_READ, B_ZERO);
            wdata_c      = '0;
            frame_done_c = !timed_out_q;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.addr       = addr_c;
   assign bus.writedata  = wdata_c;
   assign bus.chipselect = cs_c;
   assign bus.read       = rd_c;
   assign bus.write      = wr_c;
   assign in_ready       = in_ready_c;
   assign out_valid      = out_valid_c;
   assign out_data       = rdata_q;
   assign out_last       = out_valid_c && last_q;
   assign busy           = (state_q != S_IDLE);
   assign frame_done     = frame_done_c;
   assign timeout        = timeout_q;

endmodule

// File: tb/tb_nbody_bus_master.sv
module tb_nbody_bus_master;
   localparam int DW  = 64;
   localparam int AW  = 16;
   localparam int BAW = 9;
   localparam int PG  = 4;
   localparam int MP  = 4;

   logic           clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, start, load;
   logic [BAW-1:0] num_cfg, gap_cfg;
   logic           in_valid, in_ready;
   logic [DW-1:0]  in_data;
   logic           out_valid, out_ready, out_last;
   logic [DW-1:0]  out_data;
   logic           busy, frame_done, timeout;

   nbody_bus_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   nbody_bus_master #(
      .BODIES(512), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BODY_ADDR_WIDTH(BAW),
      .POLL_GAP(PG), .MAX_POLLS(MP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .load(load),
      .num_bodies_cfg(num_cfg), .gap_cfg(gap_cfg),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .frame_done(frame_done),
      .timeout(timeout), .bus(bus)
   );

   localparam logic [DW-1:0] VA = 64'hAAAA_0000_0000_0001;
   localparam logic [DW-1:0] VB = 64'hBBBB_0000_0000_0002;
   localparam logic [DW-1:0] VC = 64'hCCCC_0000_0000_0003;
   localparam logic [DW-1:0] VD = 64'hDDDD_0000_0000_0004;

   // ---------------- accelerator slave model ----------------
   int poll_total = 0;
   int poll_base;
   int done_after;
   always @(posedge clk) begin
      if (bus.chipselect && bus.read) begin
         case (bus.addr[15:9])
            7'd64: begin
               bus.readdata <= ((poll_total - poll_base) >= done_after) ? 64'd1 : 64'd0;
               poll_total   <= poll_total + 1;
            end
            7'd65:   bus.readdata <= bus.addr[0] ? VC : VA;
            7'd66:   bus.readdata <= bus.addr[0] ? VD : VB;
            default: bus.readdata <= '0;
         endcase
      end
   end

   // ---------------- bus / stream monitor ----------------
   int            cyc = 0;
   logic [AW-1:0] wa [256];
   logic [DW-1:0] wd [256];
   int            wn = 0;
   logic [AW-1:0] ra [256];
   int            rc [256];
   int            rn = 0;
   logic [DW-1:0] od [64];
   logic          ol [64];
   int            on = 0;
   int            fd_cnt = 0, to_cnt = 0, to_cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.chipselect && bus.write && wn < 256) begin
         wa[wn] <= bus.addr;
         wd[wn] <= bus.writedata;
         wn     <= wn + 1;
      end
      if (bus.chipselect && bus.read && rn < 256) begin
         ra[rn] <= bus.addr;
         rc[rn] <= cyc;
         rn     <= rn + 1;
      end
      if (out_valid && out_ready && on < 64) begin
         od[on] <= out_data;
         ol[on] <= out_last;
         on     <= on + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (timeout) begin
         to_cnt <= to_cnt + 1;
         to_cyc <= cyc;
      end
   end

   // ---------------- checking helpers ----------------
   int nvec = 0, nfail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] din;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edata;
   } ld_vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_vec_t;

   ld_vec_t lv [10];
   wr_vec_t ew [16];
   logic [AW-1:0] er [8];

   task automatic start_frame(input logic ld, input int n, input int g);
      start   = 1'b1;
      load    = ld;
      num_cfg = BAW'(n);
      gap_cfg = BAW'(g);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic feed(input ld_vec_t v, input string name);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk({name, "_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = v.din;
      #1;
      chk(name, {bus.write, bus.chipselect, bus.addr, bus.writedata},
          {1'b1, 1'b1, v.eaddr, v.edata});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_stream(input string name, input int o0);
      chk({name, "_count"}, on - o0, 4);
      chk({name, "_w0"}, od[o0],   VA);
      chk({name, "_w1"}, od[o0+1], VB);
      chk({name, "_w2"}, od[o0+2], VC);
      chk({name, "_w3"}, od[o0+3], VD);
      chk({name, "_last"}, {ol[o0], ol[o0+1], ol[o0+2], ol[o0+3]}, 4'b0001);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, o0, f0, t0, rh, k;
      logic stable;

      lv[0] = '{64'h3FF0_0000_0000_0000, 16'h0600, 64'h3FF0_0000_0000_0000};
      lv[1] = '{64'h4000_0000_0000_0000, 16'h0800, 64'h4000_0000_0000_0000};
      lv[2] = '{64'h4008_0000_0000_0000, 16'h0A00, 64'h4008_0000_0000_0000};
      lv[3] = '{64'h4010_0000_0000_0000, 16'h0C00, 64'h4010_0000_0000_0000};
      lv[4] = '{64'h4014_0000_0000_0000, 16'h0E00, 64'h4014_0000_0000_0000};
      lv[5] = '{64'h4018_0000_0000_0000, 16'h0601, 64'h4018_0000_0000_0000};
      lv[6] = '{64'h401C_0000_0000_0000, 16'h0801, 64'h401C_0000_0000_0000};
      lv[7] = '{64'h4020_0000_0000_0000, 16'h0A01, 64'h4020_0000_0000_0000};
      lv[8] = '{64'h4022_0000_0000_0000, 16'h0C01, 64'h4022_0000_0000_0000};
      lv[9] = '{64'h4024_0000_0000_0000, 16'h0E01, 64'h4024_0000_0000_0000};

      ew[0] = '{16'h0400, 64'd2};
      ew[1] = '{16'h1000, 64'd1};
      for (int i = 0; i < 10; i++) ew[2+i] = '{lv[i].eaddr, lv[i].edata};
      ew[12] = '{16'h0000, 64'd1};
      ew[13] = '{16'h0200, 64'd1};
      ew[14] = '{16'h0000, 64'd0};
      ew[15] = '{16'h0200, 64'd0};

      er[0] = 16'h8000; er[1] = 16'h8000; er[2] = 16'h8000; er[3] = 16'h8000;
      er[4] = 16'h8200; er[5] = 16'h8400; er[6] = 16'h8201; er[7] = 16'h8401;

      rst = 1'b1; start = 1'b0; load = 1'b0; num_cfg = '0; gap_cfg = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      poll_base = 0; done_after = 3;

      // ---- reset and zero-config start ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outputs",
          {busy, bus.chipselect, bus.read, bus.write, in_ready, out_valid,
           out_last, frame_done, timeout, bus.addr, bus.writedata}, '0);
      @(negedge clk);
      start_frame(1'b1, 0, 1);
      repeat (3) @(negedge clk);
      chk("zero_n_busy", busy, 1'b0);
      start_frame(1'b1, 1, 0);
      repeat (3) @(negedge clk);
      chk("zero_gap_busy", busy, 1'b0);
      chk("zero_cfg_no_bus", wn + rn, 0);

      // ---- full frame with load, 3 not-done polls ----
      w0 = wn; r0 = rn; o0 = on; f0 = fd_cnt; t0 = to_cnt;
      poll_base = poll_total; done_after = 3;
      start_frame(1'b1, 2, 1);
      for (int i = 0; i < 10; i++) begin
         feed(lv[i], $sformatf("load_beat%0d", i));
         if (i == 2) begin
            #1;
            chk("load_stall_no_write", {bus.write, bus.chipselect, in_ready}, 3'b001);
         end
      end
      wait_idle("frame1_idle", 600);
      chk("frame1_wr_count", wn - w0, 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("frame1_wr%0d", i), {wa[w0+i], wd[w0+i]}, {ew[i].addr, ew[i].data});
      chk("frame1_rd_count", rn - r0, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("frame1_rd%0d", i), ra[r0+i], er[i]);
      for (int i = 0; i < 3; i++)
         chk($sformatf("poll_spacing%0d", i), rc[r0+i+1] - rc[r0+i], PG + 3);
      check_stream("frame1_out", o0);
      chk("frame1_done_pulses", fd_cnt - f0, 1);
      chk("frame1_no_timeout", to_cnt - t0, 0);

      // ---- backpressure on word B ----
      w0 = wn; r0 = rn; o0 = on; f0 = fd_cnt;
      poll_base = poll_total; done_after = 3;
      start_frame(1'b0, 2, 1);
      k = 0;
      while (!(out_valid && out_data == VB) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("hold_B_seen", out_valid && (out_data == VB), 1'b1);
      out_ready = 1'b0;
      rh = rn;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!(out_valid && out_data == VB)) stable = 1'b0;
      end
      chk("hold_B_stable", stable, 1'b1);
      chk("hold_no_read", rn - rh, 0);
      out_ready = 1'b1;
      wait_idle("frame2_idle", 600);
      check_stream("frame2_out", o0);
      chk("frame2_wr_count", wn - w0, 6);
      chk("frame2_go_write", {wa[w0+2], wd[w0+2]}, {16'h0000, 64'd1});
      chk("frame2_done_pulses", fd_cnt - f0, 1);

      // ---- DONE never set: timeout ----
      w0 = wn; r0 = rn; o0 = on; f0 = fd_cnt; t0 = to_cnt;
      poll_base = poll_total; done_after = 1000;
      start_frame(1'b0, 1, 1);
      wait_idle("timeout_idle", 600);
      chk("timeout_pulses", to_cnt - t0, 1);
      chk("timeout_no_frame_done", fd_cnt - f0, 0);
      chk("timeout_poll_count", rn - r0, 4);
      chk("timeout_after_4th", to_cyc > rc[r0+3], 1'b1);
      chk("timeout_no_out", on - o0, 0);
      chk("timeout_wr_count", wn - w0, 5);
      chk("timeout_wr_go1",  {wa[w0+2], wd[w0+2]}, {16'h0000, 64'd1});
      chk("timeout_wr_go0",  {wa[w0+3], wd[w0+3]}, {16'h0000, 64'd0});
      chk("timeout_wr_rd0",  {wa[w0+4], wd[w0+4]}, {16'h0200, 64'd0});

      // ---- reset in LOAD at body 1 word 2, then start without load ----
      poll_base = poll_total; done_after = 0;
      start_frame(1'b1, 2, 1);
      for (int i = 0; i < 7; i++) feed(lv[i], $sformatf("rst_load_beat%0d", i));
      #1;
      chk("rst_pre_in_load", in_ready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_midload",
          {busy, bus.chipselect, bus.read, bus.write, in_ready, out_valid}, 6'b0);
      rst = 1'b0;
      @(negedge clk);
      w0 = wn; o0 = on; f0 = fd_cnt;
      poll_base = poll_total; done_after = 0;
      start_frame(1'b0, 2, 1);
      wait_idle("post_rst_idle", 600);
      chk("post_rst_wr_count", wn - w0, 6);
      chk("post_rst_wr_n",  {wa[w0],   wd[w0]},   {16'h0400, 64'd2});
      chk("post_rst_wr_go", {wa[w0+2], wd[w0+2]}, {16'h0000, 64'd1});
      check_stream("post_rst_out", o0);
      chk("post_rst_done_pulses", fd_cnt - f0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
